// File: rtl/register_file_block_pkg.sv
// Shared register-file constants for the write-back, decode and register file blocks.
package register_file_block_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  // Register index 0 always reads as zero and can never be claimed or written.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/register_file_block_reg_scoreboard.sv
// Busy scoreboard: one bit per register, marking a destination whose producer
// has issued but not yet written back. Drives the decode stall.
module reg_scoreboard
  import register_file_block_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              stall
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic                w_rs_pend;
  logic                w_rt_pend;
  logic                w_issue_ok;

  // An operand is pending while its producer is outstanding, unless the
  // write-back for it lands in this very cycle (the bypass covers it).
  always_comb begin
    w_rs_pend = (rs_addr != REG_ZERO) && r_busy[rs_addr] && !(wb_en && (wb_addr == rs_addr));
    w_rt_pend = (rt_addr != REG_ZERO) && r_busy[rt_addr] && !(wb_en && (wb_addr == rt_addr));
    stall     = w_rs_pend | w_rt_pend;
    w_issue_ok = issue_en && !stall && (issue_addr != REG_ZERO);
  end

  // Next busy vector: write-back clears first, an accepted issue then sets,
  // so a same-register issue and write-back leaves the newer claim in place.
  always_comb begin
    w_busy_next = r_busy;
    if (wb_en) begin
      w_busy_next[wb_addr] = 1'b0;
    end
    if (w_issue_ok) begin
      w_busy_next[issue_addr] = 1'b1;
    end
    w_busy_next[REG_ZERO] = 1'b0;
  end

  // Busy vector register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

endmodule

// File: rtl/register_file_block.sv
// Architectural register file: absorbs write-back data, serves two registered
// operands to decode with a same-cycle write-to-read bypass, and exposes the
// scoreboard stall.
module register_file_block
  import register_file_block_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              stall
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_rs_next;
  logic [DATA_W-1:0] w_rt_next;
  logic              w_wr_ok;

  assign w_wr_ok = wb_en && (wb_addr != REG_ZERO);

  // One flop bank per register; entry 0 is never written so it stays zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // Register gi captures write-back data when it is the destination.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_regs[gi] <= '0;
        end else if (w_wr_ok && (wb_addr == ADDR_W'(gi))) begin
          r_regs[gi] <= ans_wb;
        end
      end
    end
  endgenerate

  // Operand select: r0 reads zero, a matching write-back is forwarded,
  // otherwise the stored value is used.
  always_comb begin
    w_rs_next = '0;
    w_rt_next = '0;
    if (rs_addr != REG_ZERO) begin
      if (wb_en && (wb_addr == rs_addr)) begin
        w_rs_next = ans_wb;
      end else begin
        w_rs_next = r_regs[rs_addr];
      end
    end
    if (rt_addr != REG_ZERO) begin
      if (wb_en && (wb_addr == rt_addr)) begin
        w_rt_next = ans_wb;
      end else begin
        w_rt_next = r_regs[rt_addr];
      end
    end
  end

  // Operand output registers update every cycle, regardless of stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_data <= '0;
      rt_data <= '0;
    end else begin
      rs_data <= w_rs_next;
      rt_data <= w_rt_next;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .stall      (stall)
  );

endmodule
